// File: rtl/weight_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// weight_seq_ctrl_if
// Bundles the weight-store fetch bus (load/cs/phase -> ws_valid/ws_q) and the
// downstream weight-word stream (w_valid/w_data/w_phase <- w_ready).
//   master : sequencer view (drives load/cs/phase and the word stream)
//   slave  : store + MAC-array view
// -----------------------------------------------------------------------------
interface weight_seq_ctrl_if #(
  parameter int DATA_LEN = 8
);
  localparam int W = 36 * DATA_LEN;

  logic         load;
  logic [3:0]   cs;
  logic [2:0]   phase;
  logic         ws_valid;
  logic [W-1:0] ws_q;
  logic         w_valid;
  logic         w_ready;
  logic [W-1:0] w_data;
  logic [2:0]   w_phase;

  modport master (
    output load, cs, phase, w_valid, w_data, w_phase,
    input  ws_valid, ws_q, w_ready
  );

  modport slave (
    input  load, cs, phase, w_valid, w_data, w_phase,
    output ws_valid, ws_q, w_ready
  );
endinterface

// File: rtl/weight_seq_ctrl.sv
// -----------------------------------------------------------------------------
// weight_seq_ctrl
// Initiator side of the weight-store load/valid protocol. On start it latches
// the layer code and walks phases 0..NUM_PHASES-1: raise load, wait for the
// store's valid, capture the 36-weight word, hand it downstream over a
// valid/ready handshake, drop load for GAP_CYCLES so the store re-inits.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   start, layer      one-cycle request (IDLE only) and layer code
//   busy, done, err   status: active, end-of-layer pulse, sticky timeout
//   bus (master)      load/cs/phase/ws_valid/ws_q to the store,
//                     w_valid/w_ready/w_data/w_phase to the MAC array
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | load high, waiting for a fresh ws_valid (or timeout)
// HOLD  | word presented downstream, waiting for w_ready
// GAP   | load low for GAP_CYCLES before the next phase
// FIN   | one-cycle done pulse
// -----------------------------------------------------------------------------
module weight_seq_ctrl #(
  parameter int NUM_PHASES = 8,
  parameter int TIMEOUT    = 32,
  parameter int GAP_CYCLES = 1,
  parameter int DATA_LEN   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] layer,
  output logic       busy,
  output logic       done,
  output logic       err,
  weight_seq_ctrl_if.master bus
);

  localparam int W  = 36 * DATA_LEN;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_GAP,
    S_FIN
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cs_q, cs_d;
  logic [2:0]   phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic         err_q, err_d;
  logic [W-1:0] w_data_q, w_data_d;
  logic [2:0]   w_phase_q, w_phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cs_q      <= '0;
      phase_q   <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
      w_data_q  <= '0;
      w_phase_q <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      w_data_q  <= w_data_d;
      w_phase_q <= w_phase_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    phase_d   = phase_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    err_d     = err_q;
    w_data_d  = w_data_q;
    w_phase_d = w_phase_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cs_d    = layer;
          phase_d = '0;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        timer_d = timer_q + 1'b1;
        // timer_q == 0 marks the store's init edge, where its valid may
        // still be left over from the previous phase.
        if ((timer_q != '0) && bus.ws_valid) begin
          w_data_d  = bus.ws_q;
          w_phase_d = phase_q;
          state_d   = S_HOLD;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (bus.w_ready) begin
          if (phase_q == 3'(NUM_PHASES - 1)) begin
            state_d = S_FIN;
          end else begin
            phase_d = phase_q + 3'd1;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_LOAD;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and strobes decode straight from the state register so that an
  // async reset drops them immediately.
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err         = err_q;
  assign bus.load    = (state_q == S_LOAD);
  assign bus.w_valid = (state_q == S_HOLD);
  assign bus.cs      = cs_q;
  assign bus.phase   = phase_q;
  assign bus.w_data  = w_data_q;
  assign bus.w_phase = w_phase_q;

endmodule

// File: tb/tb_weight_seq_ctrl.sv
module tb_weight_seq_ctrl;
  localparam int DL = 8;
  localparam int W  = 36 * DL;
  localparam logic [3:0] LAYER0 = 4'd1;
  localparam logic [3:0] LAYER1 = 4'd2;
  localparam logic [3:0] LAYER2 = 4'd3;
  localparam logic [3:0] LAYER3 = 4'd4;
  localparam logic [3:0] AFFINE = 4'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, start1 = 1'b0;
  logic [3:0] layer = '0, layer1 = '0;
  logic       busy, done, err;
  logic       busy1, done1, err1;

  weight_seq_ctrl_if #(.DATA_LEN(DL)) bus ();
  weight_seq_ctrl_if #(.DATA_LEN(DL)) bus1 ();

  weight_seq_ctrl #(.NUM_PHASES(8), .TIMEOUT(32), .GAP_CYCLES(1), .DATA_LEN(DL)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer(layer),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  weight_seq_ctrl #(.NUM_PHASES(1), .TIMEOUT(32), .GAP_CYCLES(1), .DATA_LEN(DL)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .layer(layer1),
    .busy(busy1), .done(done1), .err(err1), .bus(bus1)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;

  // Stored word for a given (layer code, phase); each lane distinct.
  function automatic logic [W-1:0] word(input logic [3:0] c, input logic [2:0] p);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 36; i++)
      r[i*DL +: DL] = DL'(int'(c) * 29 + int'(p) * 11 + i * 7 + 3);
    return r;
  endfunction

  // Weight store model: valid cleared on the init edge, new word valid at
  // the 6th edge after load rise, valid left high after load falls (stale).
  logic store_dead = 1'b0;
  int   scnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt         <= 0;
      bus.ws_valid <= 1'b0;
      bus.ws_q     <= '0;
    end else if (!bus.load) begin
      scnt <= 0;
    end else begin
      scnt <= scnt + 1;
      if (scnt == 0) bus.ws_valid <= 1'b0;
      if (scnt == 4 && !store_dead) begin
        bus.ws_valid <= 1'b1;
        bus.ws_q     <= word(bus.cs, bus.phase);
      end
    end
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start(input logic [3:0] l);
    @(negedge clk);
    layer = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int used);
    used = 0;
    while (busy && used < budget) begin
      @(negedge clk);
      used++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.w_ready = 1'b0;
    bus1.w_ready = 1'b0;
    bus1.ws_valid = 1'b0;
    bus1.ws_q = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.load !== 1'b0) $display("FAIL rst_load: got %b expected 0", bus.load); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else passed++;
    total++; if (bus.w_valid !== 1'b0) $display("FAIL rst_w_valid: got %b expected 0", bus.w_valid); else passed++;
    total++; if (bus.cs !== 4'd0) $display("FAIL rst_cs: got %0h expected 0", bus.cs); else passed++;
    total++; if (bus.phase !== 3'd0) $display("FAIL rst_phase: got %0d expected 0", bus.phase); else passed++;
    total++; if (bus.w_phase !== 3'd0) $display("FAIL rst_w_phase: got %0d expected 0", bus.w_phase); else passed++;
    total++; if (bus.w_data !== '0) $display("FAIL rst_w_data: got %0h expected 0", bus.w_data); else passed++;
    total++; if (busy1 !== 1'b0) $display("FAIL rst_busy1: got %b expected 0", busy1); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_layer();
    int idx = 0, rises = 0, hold_bad = 0, cyc = 0, d0;
    logic prev_load = 1'b0;
    logic [2:0] prev_phase = '0;
    bus.w_ready = 1'b1;
    d0 = done_cnt;
    pulse_start(LAYER1);
    while (busy && cyc < 200) begin
      if (bus.load && !prev_load) rises++;
      if (bus.load && bus.cs !== LAYER1) hold_bad++;
      if (bus.load && prev_load && bus.phase !== prev_phase) hold_bad++;
      if (bus.w_valid && bus.w_ready) begin
        total++; if (bus.w_phase !== 3'(idx)) $display("FAIL full_w_phase%0d: got %0d expected %0d", idx, bus.w_phase, idx); else passed++;
        total++; if (bus.w_data !== word(LAYER1, 3'(idx))) $display("FAIL full_w_data%0d: got %0h expected %0h", idx, bus.w_data, word(LAYER1, 3'(idx))); else passed++;
        idx++;
      end
      prev_load = bus.load;
      prev_phase = bus.phase;
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc >= 200) $display("FAIL full_budget: got %0d cycles expected < 200", cyc); else passed++;
    total++; if (idx != 8) $display("FAIL full_words: got %0d expected 8", idx); else passed++;
    total++; if (rises != 8) $display("FAIL full_load_rises: got %0d expected 8", rises); else passed++;
    total++; if (hold_bad != 0) $display("FAIL full_cs_phase_stable: got %0d glitches expected 0", hold_bad); else passed++;
    total++; if (done_cnt - d0 != 1) $display("FAIL full_done: got %0d pulses expected 1", done_cnt - d0); else passed++;
  endtask

  task automatic test_backpressure();
    int cyc = 0, bad = 0, used;
    logic [W-1:0] d;
    logic [2:0] ph;
    bus.w_ready = 1'b1;
    pulse_start(LAYER2);
    while (!(bus.load && bus.phase == 3'd2) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    bus.w_ready = 1'b0;
    cyc = 0;
    while (!bus.w_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (!bus.w_valid) $display("FAIL bp_reach_hold: got w_valid %b expected 1", bus.w_valid); else passed++;
    d = bus.w_data;
    ph = bus.w_phase;
    total++; if (ph !== 3'd2) $display("FAIL bp_w_phase: got %0d expected 2", ph); else passed++;
    total++; if (d !== word(LAYER2, 3'd2)) $display("FAIL bp_w_data: got %0h expected %0h", d, word(LAYER2, 3'd2)); else passed++;
    for (int i = 0; i < 20; i++) begin
      if (bus.w_data !== d || bus.w_phase !== ph || bus.load !== 1'b0 ||
          bus.phase !== 3'd2 || bus.w_valid !== 1'b1) bad++;
      @(negedge clk);
    end
    total++; if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); else passed++;
    bus.w_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.load !== 1'b0 || bus.phase !== 3'd3) $display("FAIL bp_gap: got load %b phase %0d expected load 0 phase 3", bus.load, bus.phase); else passed++;
    @(negedge clk);
    total++; if (bus.load !== 1'b1 || bus.phase !== 3'd3) $display("FAIL bp_next_load: got load %b phase %0d expected load 1 phase 3", bus.load, bus.phase); else passed++;
    wait_idle(200, used);
    total++; if (used >= 200) $display("FAIL bp_finish: got %0d cycles expected < 200", used); else passed++;
  endtask

  task automatic test_timeout();
    int k, used, d0;
    store_dead = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    layer = LAYER0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (err) break;
    end
    total++; if (k != 32) $display("FAIL to_cycle: got err at edge %0d expected 32", k); else passed++;
    total++; if (busy !== 1'b0 || bus.load !== 1'b0) $display("FAIL to_idle: got busy %b load %b expected 0 0", busy, bus.load); else passed++;
    @(negedge clk);
    total++; if (done_cnt != d0) $display("FAIL to_no_done: got %0d pulses expected 0", done_cnt - d0); else passed++;
    store_dead = 1'b0;
    pulse_start(LAYER0);
    total++; if (err !== 1'b0) $display("FAIL to_err_clear: got %b expected 0", err); else passed++;
    wait_idle(200, used);
    total++; if (done_cnt - d0 != 1) $display("FAIL to_recover_done: got %0d pulses expected 1", done_cnt - d0); else passed++;
    total++; if (err !== 1'b0) $display("FAIL to_recover_err: got %b expected 0", err); else passed++;
  endtask

  task automatic test_start_while_busy();
    int used, d0;
    d0 = done_cnt;
    bus.w_ready = 1'b1;
    pulse_start(LAYER3);
    repeat (10) @(negedge clk);
    layer = AFFINE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (bus.cs !== LAYER3) $display("FAIL sb_cs: got %0h expected %0h", bus.cs, LAYER3); else passed++;
    wait_idle(200, used);
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL sb_no_queue: got busy %b expected 0", busy); else passed++;
    total++; if (done_cnt - d0 != 1) $display("FAIL sb_done: got %0d pulses expected 1", done_cnt - d0); else passed++;
    total++; if (bus.w_phase !== 3'd7) $display("FAIL sb_last_phase: got %0d expected 7", bus.w_phase); else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc = 0, d0;
    pulse_start(LAYER1);
    while (!(bus.load && bus.phase == 3'd3) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (!(bus.load && bus.phase == 3'd3)) $display("FAIL rm_reach: got load %b phase %0d expected 1 3", bus.load, bus.phase); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.load !== 1'b0 || bus.w_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rm_async: got load %b w_valid %b busy %b expected 0 0 0", bus.load, bus.w_valid, busy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    total++; if (done_cnt != d0 || busy !== 1'b0) $display("FAIL rm_idle: got %0d done pulses busy %b expected 0 0", done_cnt - d0, busy); else passed++;
  endtask

  task automatic test_single_phase();
    bus1.ws_valid = 1'b1;
    bus1.ws_q = '0;
    bus1.w_ready = 1'b0;
    @(negedge clk);
    layer1 = AFFINE;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    total++; if (bus1.load !== 1'b1 || bus1.cs !== AFFINE) $display("FAIL sp_load: got load %b cs %0h expected 1 %0h", bus1.load, bus1.cs, AFFINE); else passed++;
    bus1.ws_q = word(AFFINE, 3'd0);
    @(negedge clk);
    total++; if (bus1.w_valid !== 1'b0 || bus1.load !== 1'b1) $display("FAIL sp_stale: got w_valid %b load %b expected 0 1", bus1.w_valid, bus1.load); else passed++;
    @(negedge clk);
    total++; if (bus1.w_valid !== 1'b1 || bus1.load !== 1'b0) $display("FAIL sp_capture: got w_valid %b load %b expected 1 0", bus1.w_valid, bus1.load); else passed++;
    total++; if (bus1.w_data !== word(AFFINE, 3'd0) || bus1.w_phase !== 3'd0) $display("FAIL sp_word: got %0h phase %0d expected %0h phase 0", bus1.w_data, bus1.w_phase, word(AFFINE, 3'd0)); else passed++;
    bus1.ws_valid = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    bus1.w_ready = 1'b1;
    @(negedge clk);
    total++; if (done1 !== 1'b1 || busy1 !== 1'b1) $display("FAIL sp_done: got done %b busy %b expected 1 1", done1, busy1); else passed++;
    @(negedge clk);
    total++; if (done1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL sp_idle: got done %b busy %b expected 0 0", done1, busy1); else passed++;
    repeat (3) @(negedge clk);
    total++; if (busy1 !== 1'b0 || bus1.load !== 1'b0) $display("FAIL sp_no_queue: got busy %b load %b expected 0 0", busy1, bus1.load); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_backpressure();
    test_timeout();
    test_start_while_busy();
    test_reset_mid();
    test_single_phase();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/weight_seq_ctrl.md
Name: weight_seq_ctrl

Overview:
- Initiator side of the weight-store load/valid protocol.
- On a start request for one layer, it steps the weight store through phases 0..NUM_PHASES-1. For each phase it drives load/cs/phase and waits for the store's valid, then captures the 36-weight word.
- Each captured word is presented to the MAC array over a valid/ready handshake.
- Sits between the top-level layer FSM and the weight_store instances.

Parameters:
- NUM_PHASES, 8, phases fetched per layer (1..8); phase index is 3 bits.
- TIMEOUT, 32, max cycles from load rise to accepted valid before error (≥8).
- GAP_CYCLES, 1, cycles load is held low between phases (≥1), so the store re-inits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- layer  in  4  state code (`LAYER0..`LAYER3, `AFFINE from state_layer_data.v); latched on start.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse after the last phase word is accepted downstream.
- err  out  1  sticky timeout flag; cleared by next accepted start or reset.
- load  out  1  to weight store.
- cs  out  4  to weight store; latched layer code.
- phase  out  3  to weight store; current phase index.
- ws_valid  in  1  from weight store.
- ws_q  in  36*`data_len  from weight store (`data_len from num_data.v).
- w_valid  out  1  downstream word valid.
- w_ready  in  1  downstream accept.
- w_data  out  36*`data_len  captured weight word.
- w_phase  out  3  phase index of w_data.

Behaviour:
- Reset (async, rst_n=0): state IDLE; load=0, busy=0, done=0, err=0, w_valid=0, cs=0, phase=0, w_phase=0, w_data=0, counters=0. Reset mid-fetch aborts immediately; no done is produced.
- States: IDLE, LOAD, HOLD, GAP, FIN.
- IDLE + start:
  - latch cs<=layer; phase<=0; busy<=1; err<=0; timer<=0.
  - next state LOAD; load goes high the following cycle.
- LOAD:
  - load=1; timer increments each cycle.
  - ws_valid is ignored on the first clock edge with load=1, because the store's valid can be stale from the previous phase and is cleared only on its init edge.
  - From the second edge on, ws_valid=1 captures w_data<=ws_q and w_phase<=phase, sets w_valid<=1, deasserts load, and moves to HOLD.
  - Nominal store latency: valid is seen 6 edges after load rise.
  - If timer reaches TIMEOUT without capture: err<=1, load<=0, busy<=0, next state IDLE, no done pulse.
- HOLD:
  - w_valid=1 and w_data stable until w_ready=1 at an edge.
  - On handshake: w_valid<=0.
  - If phase==NUM_PHASES-1, go to FIN.
  - Otherwise phase<=phase+1, gap counter<=0, go to GAP.
  - No timeout in HOLD; backpressure is unbounded.
- GAP:
  - load=0 for exactly GAP_CYCLES cycles, then timer<=0 and go to LOAD.
  - phase changes only while load=0.
- FIN: done=1 for one cycle, busy<=0, go to IDLE.
- start asserted while busy is ignored; no queuing.
- cs and phase are held constant throughout each load-high window.
- Per-phase cost with w_ready tied high: about 6 cycles in LOAD, 1 in HOLD, GAP_CYCLES in GAP.
- phase never wraps; with NUM_PHASES=8 the last index is 7, after which the block terminates.

Test Plan:
- Reset during LOAD at phase 3 → load, w_valid, busy go 0 asynchronously; after release, IDLE; no done pulse.
- start with layer=`LAYER1, w_ready=1, real weight_store_7 model → w_phase 0..7 delivered in order; each w_data equals the ROM words at addresses 32+4p..32+4p+3 concatenated; done pulses once; load goes low between every phase.
- Stale valid: store holds valid=1 from the previous phase when load rises → the first-edge valid is not captured; the captured word is the new phase's word, not a repeat.
- Backpressure: w_ready=0 for 20 cycles in HOLD of phase 2 → w_data/w_phase stable, load stays 0, phase stays 2; on release, phase 3 fetch begins after GAP_CYCLES.
- Timeout: ws_valid tied 0 → err=1 and busy=0 at cycle TIMEOUT (32) after load rise; next start clears err and completes normally.
- start pulsed while busy, and NUM_PHASES=1 build → extra start ignored; single word delivered, then done.
